// File: rtl/rc4_mem_pkg.sv
// Shared constants and state type for the RC4 S-array memory responder.
package rc4_mem_pkg;
    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;
    localparam int S_DEPTH  = 256;

    typedef enum logic {
        FILL,
        READY
    } s_mem_state_t;
endpackage

// File: rtl/s_ram_core.sv
// Single-port synchronous RAM with registered, write-first read data.
module s_ram_core
    import rc4_mem_pkg::*;
#(
    parameter int ADDR_W = S_ADDR_W,
    parameter int DATA_W = S_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = we ? wdata : mem[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register holds its value between reads so q is stable when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/s_mem_responder.sv
// S-array responder: identity self-fill, fixed-latency reads, drop flag.
module s_mem_responder
    import rc4_mem_pkg::*;
#(
    parameter int ADDR_W        = S_ADDR_W,
    parameter int DATA_W        = S_DATA_W,
    parameter int READ_LAT      = 2,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              rden,
    input  logic              wren,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    input  logic              init_req,
    output logic              init_busy,
    output logic              init_done,
    output logic              drop_err
);
    localparam s_mem_state_t RST_STATE = (INIT_ON_RESET != 0) ? FILL : READY;
    localparam logic [ADDR_W-1:0] LAST = '1;

    s_mem_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              drop_q, drop_d;
    logic              v1_q, v1_d;

    logic              ram_we, ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (cnt_q == LAST) state_d = READY;
            READY:   if (init_req) state_d = FILL;
            default: state_d = RST_STATE;
        endcase
    end

    // Fill writes own the RAM port; initiator requests only reach it in READY.
    always_comb begin
        cnt_d     = cnt_q;
        done_d    = done_q;
        drop_d    = drop_q;
        v1_d      = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = address;
        ram_wdata = data;
        init_busy = 1'b0;
        unique case (state_q)
            FILL: begin
                init_busy = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = cnt_q;
                ram_wdata = DATA_W'(cnt_q);
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) done_d = 1'b1;
                if (rden || wren) drop_d = 1'b1;
            end
            READY: begin
                ram_we = wren;
                ram_re = rden;
                v1_d   = rden;
                if (init_req) begin
                    cnt_d  = '0;
                    done_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            drop_q <= 1'b0;
            v1_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            drop_q <= drop_d;
            v1_q   <= v1_d;
        end
    end

    s_ram_core #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clk  (clk),
        .reset(reset),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    if (READ_LAT == 1) begin : g_lat1
        assign q       = ram_rdata;
        assign q_valid = v1_q;
    end else begin : g_lat2
        logic [DATA_W-1:0] q2_q, q2_d;
        logic              qv_q, qv_d;

        always_comb begin
            q2_d = v1_q ? ram_rdata : q2_q;
            qv_d = v1_q;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q2_q <= '0;
                qv_q <= 1'b0;
            end else begin
                q2_q <= q2_d;
                qv_q <= qv_d;
            end
        end

        assign q       = q2_q;
        assign q_valid = qv_q;
    end

    assign init_done = done_q;
    assign drop_err  = drop_q;
endmodule

// File: doc/s_mem_responder.md
Name: s_mem_responder

Overview:
- Responder end of the 256x8 S-array memory interface used by the RC4 key-schedule and decrypt FSMs. Those FSMs drive address, data, rden and wren, and sample q.
- Holds the S array and returns read data with a fixed registered latency that matches the initiators' request/wait/record cadence.
- Self-fills the identity permutation S[i]=i after reset, or on request, so no initiator needs a separate init pass.
- Flags any request that arrives while it is busy filling.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W.
- DATA_W, 8, data width; must be at least ADDR_W for the identity fill.
- READ_LAT, 2, read latency in cycles; only 1 and 2 are legal.
- INIT_ON_RESET, 1, 1 = fill starts automatically when reset is released; 0 = fill starts only on init_req.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- address  in  ADDR_W  request address.
- data  in  DATA_W  write data.
- rden  in  1  read request; sampled every clock edge.
- wren  in  1  write request; sampled every clock edge.
- q  out  DATA_W  read data.
- q_valid  out  1  high for one cycle when q carries a completed read.
- init_req  in  1  in READY, a single-cycle pulse starts a new identity fill.
- init_busy  out  1  high while a fill is in progress.
- init_done  out  1  high once a fill has completed; cleared when a new fill starts.
- drop_err  out  1  sticky; set when a request is dropped during a fill; cleared only by reset.

Behaviour:
- Reset values:
  - q = 0, q_valid = 0, drop_err = 0, init_done = 0.
  - init_busy = INIT_ON_RESET; fill counter = 0.
  - State = FILL if INIT_ON_RESET = 1, otherwise READY.
  - Memory contents are not cleared by reset.
- State machine:
  - FILL: each cycle writes mem[k] <= k, then k <= k+1. After the write of k = 2**ADDR_W-1, the next state is READY and init_done <= 1 on that same edge. A fill takes exactly 2**ADDR_W cycles.
  - READY: serves requests. If init_req = 1: k <= 0, state <= FILL, init_busy <= 1, init_done <= 0. A request arriving on the same edge as init_req is still served.
- Requests in READY, sampled at edge E:
  - wren = 1: mem[address] <= data at edge E.
  - rden = 1: READ_LAT = 1 gives q/q_valid valid after edge E; READ_LAT = 2 gives q/q_valid valid after edge E+1 (output register).
  - rden and wren on the same address in the same cycle: write-first; q returns the new data.
  - A read at a later edge returns the most recent write.
- Pipelining:
  - Back-to-back reads are accepted every cycle; q_valid is a READ_LAT-deep shift of rden.
  - q holds its last value when q_valid = 0.
- Requests during FILL: rden or wren high is ignored (no write, no q_valid) and drop_err <= 1.
- Reset mid-fill: aborts the fill and restarts per INIT_ON_RESET. Any read still in the pipeline is discarded (q_valid = 0).
- Width rules: the fill counter is ADDR_W bits and wraps naturally. Fill data is the counter zero-extended to DATA_W.

Decomposition:
- Package rc4_mem_pkg holds:
  - S_ADDR_W = 8, S_DATA_W = 8, S_DEPTH = 256.
  - Enum s_mem_state_t {FILL, READY}.
- Sub-module s_ram_core: plain single-port synchronous array, one write port, registered read, write-first.
- s_mem_responder holds:
  - the fill FSM;
  - the request muxing between fill writes and initiator requests;
  - the valid/latency pipeline;
  - the error flag.

Test Plan:
- Reset release with INIT_ON_RESET = 1: init_busy = 1 for exactly 256 cycles, then init_done = 1. Reads of 0x00, 0x37 and 0xFF return 0x00, 0x37 and 0xFF.
- READ_LAT = 2, read 0x10 at edge E: q = 0x10 and q_valid = 1 only in the cycle after E+1. q_valid = 0 in the cycle after E.
- Write 0xA5 to 0x20 with rden = 1 on the same edge: q = 0xA5 with q_valid after the latency. A subsequent read of 0x20 returns 0xA5.
- Back-to-back reads of 0x01, 0x02, 0x03: q_valid high for 3 consecutive cycles, q = 0x01, 0x02, 0x03.
- wren = 1 with address 0x05 and data 0xEE during FILL: drop_err = 1 and stays 1. After the fill, address 0x05 reads 0x05.
- Assert reset at fill count 100, release, and pulse init_req in READY after a write of 0x99 to 0x40:
  - After the reset, the fill restarts and takes a full 256 cycles.
  - After the init_req fill, address 0x40 reads 0x40 again.
